// File: rtl/seq_pkg.sv
// Shared definitions for the bit-serial sequence serializer and its detectors.
// Holds the serializer state encoding, default word geometry and the two
// detector target patterns so serializer and detector benches agree on them.
package seq_pkg;

    localparam int unsigned WORD_W_DEF = 16;
    localparam int unsigned LEN_W_DEF  = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLR   = 2'd1,
        ST_SHIFT = 2'd2,
        ST_GAP   = 2'd3
    } state_t;

    localparam logic [4:0] PAT_11011 = 5'b11011;
    localparam logic [4:0] PAT_11101 = 5'b11101;

endpackage

// File: rtl/seq_bit_serializer_if.sv
// Upstream word handshake for seq_bit_serializer.
//   in_valid  : word offered
//   in_ready  : serializer can take a word this cycle
//   in_data   : word, meaningful bits in_data[in_len-1:0]
//   in_len    : number of bits to send
//   in_clear  : pulse det_rst before this word
// master = word producer, slave = serializer.
interface seq_bit_serializer_if #(
    parameter int unsigned WORD_W = 16,
    parameter int unsigned LEN_W  = 5
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic [LEN_W-1:0]  in_len;
    logic              in_clear;

    modport master (
        output in_valid,
        output in_data,
        output in_len,
        output in_clear,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  in_len,
        input  in_clear,
        output in_ready
    );
endinterface

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial feeder for the bit-serial sequence detectors.
// Takes words over a valid/ready handshake and shifts them out MSB-first,
// one bit per clock, optionally preceded by a one-cycle detector reset and
// followed by GAP idle cycles.
//   clk, rst  : clock, synchronous active-high reset
//   up        : word handshake (slave side)
//   a_out     : serial bit to detector input
//   bit_valid : a_out carries a word bit this cycle
//   det_rst   : one-cycle reset pulse to the detector
//   busy      : serializer is not idle
module seq_bit_serializer
    import seq_pkg::*;
#(
    parameter int unsigned WORD_W = WORD_W_DEF,
    parameter int unsigned LEN_W  = LEN_W_DEF,
    parameter int unsigned GAP    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    seq_bit_serializer_if.slave   up,
    output logic                  a_out,
    output logic                  bit_valid,
    output logic                  det_rst,
    output logic                  busy
);

    localparam int unsigned GAP_W = (GAP > 0) ? $clog2(GAP + 1) : 1;

    state_t            state, state_next;
    logic [WORD_W-1:0] shreg, shreg_next;
    logic [LEN_W-1:0]  cnt, cnt_next;
    logic [GAP_W-1:0]  gcnt, gcnt_next;

    logic              a_out_next;
    logic              bit_valid_next;
    logic              det_rst_next;
    logic              busy_next;

    logic              accept;
    logic [LEN_W-1:0]  len_eff;
    logic [WORD_W-1:0] shreg_load;

    assign up.in_ready = (state == ST_IDLE) && !rst;
    assign accept      = up.in_valid && up.in_ready;

    // Clamp over-long requests to the register width.
    assign len_eff = (up.in_len > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : up.in_len;

    // Left-align so in_data[len-1] lands in the MSB and goes out first.
    assign shreg_load = up.in_data << (LEN_W'(WORD_W) - len_eff);

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shreg     <= '0;
            cnt       <= '0;
            gcnt      <= '0;
            a_out     <= 1'b0;
            bit_valid <= 1'b0;
            det_rst   <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_next;
            shreg     <= shreg_next;
            cnt       <= cnt_next;
            gcnt      <= gcnt_next;
            a_out     <= a_out_next;
            bit_valid <= bit_valid_next;
            det_rst   <= det_rst_next;
            busy      <= busy_next;
        end
    end

    // Next state, shift register, bit counter and gap counter.
    always_comb begin
        state_next = state;
        shreg_next = shreg;
        cnt_next   = cnt;
        gcnt_next  = gcnt;
        case (state)
            ST_IDLE: begin
                // A zero-length word is consumed by the handshake and dropped.
                if (accept && (len_eff != '0)) begin
                    shreg_next = shreg_load;
                    cnt_next   = len_eff;
                    state_next = up.in_clear ? ST_CLR : ST_SHIFT;
                end
            end
            ST_CLR: begin
                state_next = ST_SHIFT;
            end
            ST_SHIFT: begin
                shreg_next = {shreg[WORD_W-2:0], 1'b0};
                cnt_next   = cnt - LEN_W'(1);
                if (cnt == LEN_W'(1)) begin
                    if (GAP > 0) begin
                        state_next = ST_GAP;
                        gcnt_next  = GAP_W'(GAP);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_GAP: begin
                gcnt_next = gcnt - GAP_W'(1);
                if (gcnt <= GAP_W'(1)) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Output decode from the upcoming state, so registered outputs line up
    // with the state they describe.
    always_comb begin
        a_out_next     = 1'b0;
        bit_valid_next = 1'b0;
        det_rst_next   = 1'b0;
        busy_next      = (state_next != ST_IDLE);
        case (state_next)
            ST_CLR: begin
                det_rst_next = 1'b1;
            end
            ST_SHIFT: begin
                bit_valid_next = 1'b1;
                a_out_next     = shreg_next[WORD_W-1];
            end
            default: begin
                a_out_next = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: one GAP=1 instance and one GAP=0
// instance sharing clock and reset. Each check compares the packed vector
// {det_rst, bit_valid, a_out, busy, in_ready} against a hand-derived value.
module tb_seq_bit_serializer;
    import seq_pkg::*;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned LEN_W  = 5;

    logic clk;
    logic rst;

    logic a_out1, bit_valid1, det_rst1, busy1;
    logic a_out0, bit_valid0, det_rst0, busy0;

    int tests;
    int fails;

    seq_bit_serializer_if #(.WORD_W(WORD_W), .LEN_W(LEN_W)) bus1 ();
    seq_bit_serializer_if #(.WORD_W(WORD_W), .LEN_W(LEN_W)) bus0 ();

    seq_bit_serializer #(.WORD_W(WORD_W), .LEN_W(LEN_W), .GAP(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .up        (bus1),
        .a_out     (a_out1),
        .bit_valid (bit_valid1),
        .det_rst   (det_rst1),
        .busy      (busy1)
    );

    seq_bit_serializer #(.WORD_W(WORD_W), .LEN_W(LEN_W), .GAP(0)) dut0 (
        .clk       (clk),
        .rst       (rst),
        .up        (bus0),
        .a_out     (a_out0),
        .bit_valid (bit_valid0),
        .det_rst   (det_rst0),
        .busy      (busy0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] obs1();
        return {det_rst1, bit_valid1, a_out1, busy1, bus1.in_ready};
    endfunction

    function automatic logic [4:0] obs0();
        return {det_rst0, bit_valid0, a_out0, busy0, bus0.in_ready};
    endfunction

    // Expected vector for a cycle carrying word bit b.
    function automatic logic [4:0] bitv(input logic b);
        return {1'b0, 1'b1, b, 1'b1, 1'b0};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [4:0] observed, input logic [4:0] expected);
        tests++;
        assert (observed === expected)
        else begin
            fails++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    initial begin
        logic [4:0]  pat;
        logic [15:0] wd;

        tests = 0;
        fails = 0;
        rst   = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = '0; bus1.in_len = '0; bus1.in_clear = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = '0; bus0.in_len = '0; bus0.in_clear = 1'b0;

        // Reset: all outputs low, in_ready held low during rst.
        tick();
        tick();
        chk("reset_outs", obs1(), 5'b00000);
        chk("reset_outs_gap0", obs0(), 5'b00000);
        rst = 1'b0;
        #1;
        chk("post_reset_ready", obs1(), 5'b00001);

        // Test 1: 11011 with clear, GAP=1.
        bus1.in_data = 16'h001B; bus1.in_len = 5'd5; bus1.in_clear = 1'b1; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("t1_clr", obs1(), 5'b10010);
        pat = PAT_11011;
        for (int i = 4; i >= 0; i--) begin
            tick();
            chk($sformatf("t1_bit%0d", 4 - i), obs1(), bitv(pat[i]));
        end
        tick();
        chk("t1_gap", obs1(), 5'b00010);
        tick();
        chk("t1_idle", obs1(), 5'b00001);

        // Test 2: back-to-back, second word held valid and changed while busy.
        bus1.in_data = 16'h001D; bus1.in_len = 5'd5; bus1.in_clear = 1'b0; bus1.in_valid = 1'b1;
        tick();
        bus1.in_data = 16'h0003; bus1.in_len = 5'd2;
        pat = PAT_11101;
        for (int i = 4; i >= 0; i--) begin
            chk($sformatf("t2_w1_bit%0d", 4 - i), obs1(), bitv(pat[i]));
            tick();
        end
        chk("t2_gap", obs1(), 5'b00010);
        tick();
        chk("t2_idle", obs1(), 5'b00001);
        tick();
        bus1.in_valid = 1'b0;
        chk("t2_w2_bit0", obs1(), bitv(1'b1));
        tick();
        chk("t2_w2_bit1", obs1(), bitv(1'b1));
        tick();
        chk("t2_w2_gap", obs1(), 5'b00010);
        tick();
        chk("t2_w2_idle", obs1(), 5'b00001);

        // Test 3: zero-length word is consumed without any activity.
        bus1.in_data = 16'hFFFF; bus1.in_len = 5'd0; bus1.in_clear = 1'b1; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("t3_len0", obs1(), 5'b00001);
        tick();
        chk("t3_len0_after", obs1(), 5'b00001);

        // Test 4: over-long length clamps to 16 bits.
        wd = 16'h8001;
        bus1.in_data = wd; bus1.in_len = 5'd20; bus1.in_clear = 1'b0; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        for (int i = 15; i >= 0; i--) begin
            chk($sformatf("t4_bit%0d", 15 - i), obs1(), bitv(wd[i]));
            tick();
        end
        chk("t4_gap", obs1(), 5'b00010);
        tick();
        chk("t4_idle", obs1(), 5'b00001);

        // Test 5: reset during the third bit aborts the word.
        bus1.in_data = 16'h001B; bus1.in_len = 5'd5; bus1.in_clear = 1'b0; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("t5_bit0", obs1(), bitv(1'b1));
        tick();
        chk("t5_bit1", obs1(), bitv(1'b1));
        tick();
        chk("t5_bit2", obs1(), bitv(1'b0));
        rst = 1'b1;
        tick();
        chk("t5_rst", obs1(), 5'b00000);
        rst = 1'b0;
        #1;
        chk("t5_ready", obs1(), 5'b00001);
        bus1.in_data = 16'h0001; bus1.in_len = 5'd1; bus1.in_clear = 1'b0; bus1.in_valid = 1'b1;
        tick();
        bus1.in_valid = 1'b0;
        chk("t5_single", obs1(), bitv(1'b1));
        tick();
        chk("t5_gap", obs1(), 5'b00010);
        tick();
        chk("t5_idle", obs1(), 5'b00001);

        // Test 6: GAP=0, repeated 1-bit words with clear, period 3.
        chk("t6_idle0", obs0(), 5'b00001);
        bus0.in_data = 16'h0001; bus0.in_len = 5'd1; bus0.in_clear = 1'b1; bus0.in_valid = 1'b1;
        for (int w = 0; w < 3; w++) begin
            tick();
            if (w == 2) bus0.in_valid = 1'b0;
            chk($sformatf("t6_w%0d_clr", w), obs0(), 5'b10010);
            tick();
            chk($sformatf("t6_w%0d_bit", w), obs0(), bitv(1'b1));
            tick();
            chk($sformatf("t6_w%0d_idle", w), obs0(), 5'b00001);
        end
        tick();
        chk("t6_quiet", obs0(), 5'b00001);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
